// File: rtl/exec_req_initiator.sv
// Initiator side of the execution-unit request/response protocol: tags host
// commands with 3-bit IDs, issues them, and retires out-of-order responses in issue order.
package exec_req_pkg;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              req;
    logic              req_type;
    logic [2:0]        req_id;
    logic [DATA_W-1:0] req_data1;
    logic [DATA_W-1:0] req_data2;
  } req_pkt_type;

  typedef struct packed {
    logic        rsp;
    logic [2:0]  rsp_id;
    logic [63:0] rsp_data;
  } rsp_pkt_type;
endpackage

module exec_req_initiator
  import exec_req_pkg::*;
#(
  parameter int NUM_IDS = 8,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_type,
  input  logic [DATA_W-1:0] cmd_data1,
  input  logic [DATA_W-1:0] cmd_data2,
  input  logic              fifo_full,
  output req_pkt_type       output_req,
  input  rsp_pkt_type       input_rsp,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2:0]        res_id,
  output logic [63:0]       res_data,
  output logic [3:0]        outstanding,
  output logic              proto_err,
  output logic              timeout_err
);

  localparam logic [3:0]    MAX_CNT = 4'(NUM_IDS);
  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  logic [2:0]         iss_ptr_r;
  logic [2:0]         ret_ptr_r;
  logic [3:0]         count_r;
  logic [3:0]         count_nxt_s;
  logic [NUM_IDS-1:0] inflight_r;
  logic [NUM_IDS-1:0] done_r;
  logic [63:0]        data_r [NUM_IDS];
  logic [TW-1:0]      tmo_cnt_r;
  logic [TW-1:0]      tmo_nxt_s;
  logic               proto_err_r;
  logic               timeout_err_r;
  logic               issue_s;
  logic               retire_s;
  logic               res_valid_s;
  logic               rsp_slot_open_s;
  logic               rsp_ok_s;
  logic               rsp_bad_s;

  assign cmd_ready       = rst_b && !fifo_full && (count_r < MAX_CNT);
  assign issue_s         = cmd_valid && cmd_ready;
  assign res_valid_s     = done_r[ret_ptr_r] && (count_r != 4'd0);
  assign retire_s        = res_valid_s && res_ready;
  // A response to the ID retiring this cycle still sees done set, so it is rejected
  assign rsp_slot_open_s = inflight_r[input_rsp.rsp_id] && !done_r[input_rsp.rsp_id];
  assign rsp_ok_s        = input_rsp.rsp && rsp_slot_open_s;
  assign rsp_bad_s       = input_rsp.rsp && !rsp_slot_open_s;

  assign res_valid   = res_valid_s;
  assign res_id      = ret_ptr_r;
  assign res_data    = data_r[ret_ptr_r];
  assign outstanding = count_r;
  assign proto_err   = proto_err_r;
  assign timeout_err = timeout_err_r;

  // Zero-latency request packet, all fields quiet when nothing is issued
  always_comb begin
    output_req = '0;
    if (issue_s) begin
      output_req.req       = 1'b1;
      output_req.req_type  = cmd_type;
      output_req.req_id    = iss_ptr_r;
      output_req.req_data1 = cmd_data1;
      output_req.req_data2 = cmd_data2;
    end else begin
      output_req = '0;
    end
  end

  // Outstanding count update from issue/retire pair
  always_comb begin
    count_nxt_s = count_r;
    case ({issue_s, retire_s})
      2'b10:   count_nxt_s = count_r + 4'd1;
      2'b01:   count_nxt_s = count_r - 4'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Oldest-request wait counter, saturating at TIMEOUT
  always_comb begin
    tmo_nxt_s = tmo_cnt_r;
    if ((count_r == 4'd0) || retire_s || done_r[ret_ptr_r]) begin
      tmo_nxt_s = '0;
    end else if (tmo_cnt_r == TMO_MAX) begin
      tmo_nxt_s = tmo_cnt_r;
    end else begin
      tmo_nxt_s = tmo_cnt_r + TW'(1);
    end
  end

  // Bookkeeping state; issue, capture and retire never target the same ID in one cycle
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      iss_ptr_r     <= 3'd0;
      ret_ptr_r     <= 3'd0;
      count_r       <= 4'd0;
      inflight_r    <= '0;
      done_r        <= '0;
      tmo_cnt_r     <= '0;
      proto_err_r   <= 1'b0;
      timeout_err_r <= 1'b0;
      for (int i = 0; i < NUM_IDS; i++) begin
        data_r[i] <= 64'd0;
      end
    end else begin
      if (issue_s) begin
        inflight_r[iss_ptr_r] <= 1'b1;
        done_r[iss_ptr_r]     <= 1'b0;
        iss_ptr_r             <= iss_ptr_r + 3'd1;
      end
      if (rsp_ok_s) begin
        done_r[input_rsp.rsp_id] <= 1'b1;
        data_r[input_rsp.rsp_id] <= input_rsp.rsp_data;
      end
      if (retire_s) begin
        inflight_r[ret_ptr_r] <= 1'b0;
        done_r[ret_ptr_r]     <= 1'b0;
        ret_ptr_r             <= ret_ptr_r + 3'd1;
      end
      count_r       <= count_nxt_s;
      tmo_cnt_r     <= tmo_nxt_s;
      proto_err_r   <= proto_err_r | rsp_bad_s;
      timeout_err_r <= timeout_err_r | (tmo_cnt_r == TMO_MAX);
    end
  end

endmodule

// File: tb/tb_exec_req_initiator.sv
// Directed bench for exec_req_initiator: issue, reorder, backpressure,
// capacity/wrap, error flags and mid-flight reset.
module tb_exec_req_initiator;
  import exec_req_pkg::*;

  logic        clk;
  logic        rst_b;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_type;
  logic [31:0] cmd_data1;
  logic [31:0] cmd_data2;
  logic        fifo_full;
  req_pkt_type output_req;
  rsp_pkt_type input_rsp;
  logic        res_valid;
  logic        res_ready;
  logic [2:0]  res_id;
  logic [63:0] res_data;
  logic [3:0]  outstanding;
  logic        proto_err;
  logic        timeout_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  exec_req_initiator #(.NUM_IDS(8), .TIMEOUT(256)) dut (
    .clk(clk), .rst_b(rst_b), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_data1(cmd_data1), .cmd_data2(cmd_data2),
    .fifo_full(fifo_full), .output_req(output_req), .input_rsp(input_rsp),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_data(res_data), .outstanding(outstanding), .proto_err(proto_err),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_type = 1'b0; cmd_data1 = 32'd0; cmd_data2 = 32'd0;
    fifo_full = 1'b0; res_ready = 1'b0; input_rsp = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_b = 1'b0;
    tick();
    tick();
    rst_b = 1'b1;
  endtask

  task automatic set_cmd(input logic t, input logic [31:0] a, input logic [31:0] b);
    cmd_valid = 1'b1; cmd_type = t; cmd_data1 = a; cmd_data2 = b;
  endtask

  task automatic set_rsp(input logic [2:0] id, input logic [63:0] d);
    input_rsp.rsp = 1'b1; input_rsp.rsp_id = id; input_rsp.rsp_data = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_b = 1'b0;
    cmd_valid = 1'b1;
    tick();
    tick();
    vec_cnt++; if (cmd_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_cmd_ready: got %0b expected 0", cmd_ready); end
    vec_cnt++; if (output_req !== '0) begin err_cnt++; $display("FAIL rst_output_req: got %0h expected 0", output_req); end
    vec_cnt++; if (outstanding !== 4'd0) begin err_cnt++; $display("FAIL rst_outstanding: got %0d expected 0", outstanding); end
    vec_cnt++; if (res_valid !== 1'b0 || res_id !== 3'd0 || res_data !== 64'd0) begin err_cnt++; $display("FAIL rst_result: got v=%0b id=%0d d=%0h expected 0/0/0", res_valid, res_id, res_data); end
    vec_cnt++; if (proto_err !== 1'b0 || timeout_err !== 1'b0) begin err_cnt++; $display("FAIL rst_errors: got %0b%0b expected 00", proto_err, timeout_err); end
    cmd_valid = 1'b0;
    rst_b = 1'b1;
    #1;
    vec_cnt++; if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_release_ready: got %0b expected 1", cmd_ready); end
  endtask

  task automatic test_single_add();
    do_reset();
    set_cmd(1'b0, 32'd5, 32'd7);
    #1;
    vec_cnt++; if (output_req.req !== 1'b1 || output_req.req_id !== 3'd0 || output_req.req_type !== 1'b0 || output_req.req_data1 !== 32'd5 || output_req.req_data2 !== 32'd7) begin err_cnt++; $display("FAIL add_issue: got %0h expected req=1 id=0 type=0 d1=5 d2=7", output_req); end
    tick();
    idle_inputs();
    vec_cnt++; if (outstanding !== 4'd1 || res_valid !== 1'b0) begin err_cnt++; $display("FAIL add_pending: got out=%0d v=%0b expected 1/0", outstanding, res_valid); end
    set_rsp(3'd0, 64'd12);
    tick();
    idle_inputs();
    vec_cnt++; if (res_valid !== 1'b1 || res_id !== 3'd0 || res_data !== 64'd12) begin err_cnt++; $display("FAIL add_result: got v=%0b id=%0d d=%0d expected 1/0/12", res_valid, res_id, res_data); end
    tick();
    vec_cnt++; if (res_valid !== 1'b1 || res_data !== 64'd12) begin err_cnt++; $display("FAIL add_hold: got v=%0b d=%0d expected 1/12", res_valid, res_data); end
    // retire while a duplicate for the same ID arrives
    res_ready = 1'b1;
    set_rsp(3'd0, 64'd99);
    tick();
    idle_inputs();
    vec_cnt++; if (outstanding !== 4'd0 || res_valid !== 1'b0) begin err_cnt++; $display("FAIL add_retire: got out=%0d v=%0b expected 0/0", outstanding, res_valid); end
    vec_cnt++; if (proto_err !== 1'b1) begin err_cnt++; $display("FAIL add_dup_proto: got %0b expected 1", proto_err); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    set_cmd(1'b1, 32'd3, 32'd4);
    tick();
    set_cmd(1'b0, 32'd1, 32'd1);
    #1;
    vec_cnt++; if (output_req.req !== 1'b1 || output_req.req_id !== 3'd1) begin err_cnt++; $display("FAIL ooo_second_id: got req=%0b id=%0d expected 1/1", output_req.req, output_req.req_id); end
    tick();
    idle_inputs();
    set_rsp(3'd1, 64'd2);
    tick();
    idle_inputs();
    vec_cnt++; if (res_valid !== 1'b0 || proto_err !== 1'b0) begin err_cnt++; $display("FAIL ooo_wait_head: got v=%0b perr=%0b expected 0/0", res_valid, proto_err); end
    set_rsp(3'd0, 64'd12);
    tick();
    idle_inputs();
    vec_cnt++; if (res_valid !== 1'b1 || res_id !== 3'd0 || res_data !== 64'd12) begin err_cnt++; $display("FAIL ooo_first: got v=%0b id=%0d d=%0d expected 1/0/12", res_valid, res_id, res_data); end
    res_ready = 1'b1;
    tick();
    vec_cnt++; if (res_valid !== 1'b1 || res_id !== 3'd1 || res_data !== 64'd2) begin err_cnt++; $display("FAIL ooo_second: got v=%0b id=%0d d=%0d expected 1/1/2", res_valid, res_id, res_data); end
    tick();
    res_ready = 1'b0;
    vec_cnt++; if (res_valid !== 1'b0 || outstanding !== 4'd0) begin err_cnt++; $display("FAIL ooo_drained: got v=%0b out=%0d expected 0/0", res_valid, outstanding); end
  endtask

  task automatic test_backpressure();
    do_reset();
    fifo_full = 1'b1;
    set_cmd(1'b0, 32'd9, 32'd9);
    #1;
    vec_cnt++; if (cmd_ready !== 1'b0 || output_req.req !== 1'b0) begin err_cnt++; $display("FAIL bp_blocked: got rdy=%0b req=%0b expected 0/0", cmd_ready, output_req.req); end
    tick();
    vec_cnt++; if (outstanding !== 4'd0) begin err_cnt++; $display("FAIL bp_no_issue: got %0d expected 0", outstanding); end
    fifo_full = 1'b0;
    #1;
    vec_cnt++; if (cmd_ready !== 1'b1 || output_req.req !== 1'b1 || output_req.req_id !== 3'd0) begin err_cnt++; $display("FAIL bp_release: got rdy=%0b req=%0b id=%0d expected 1/1/0", cmd_ready, output_req.req, output_req.req_id); end
    tick();
    idle_inputs();
    vec_cnt++; if (outstanding !== 4'd1) begin err_cnt++; $display("FAIL bp_issued: got %0d expected 1", outstanding); end
  endtask

  task automatic test_capacity_wrap();
    logic [2:0] eid;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_cmd(1'b0, 32'(i), 32'd1);
      tick();
    end
    #1;
    vec_cnt++; if (outstanding !== 4'd8 || cmd_ready !== 1'b0 || output_req.req !== 1'b0) begin err_cnt++; $display("FAIL cap_full: got out=%0d rdy=%0b req=%0b expected 8/0/0", outstanding, cmd_ready, output_req.req); end
    set_rsp(3'd0, 64'd100);
    tick();
    input_rsp = '0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    #1;
    vec_cnt++; if (outstanding !== 4'd7 || cmd_ready !== 1'b1 || output_req.req_id !== 3'd0 || res_id !== 3'd1) begin err_cnt++; $display("FAIL cap_reuse: got out=%0d rdy=%0b id=%0d ret=%0d expected 7/1/0/1", outstanding, cmd_ready, output_req.req_id, res_id); end
    tick();
    idle_inputs();
    for (int k = 0; k < 8; k++) begin
      eid = 3'(k + 1);
      set_rsp(eid, 64'(200 + k));
      tick();
      input_rsp = '0;
      vec_cnt++; if (res_valid !== 1'b1 || res_id !== eid || res_data !== 64'(200 + k)) begin err_cnt++; $display("FAIL cap_drain_%0d: got v=%0b id=%0d d=%0d expected 1/%0d/%0d", k, res_valid, res_id, res_data, eid, 200 + k); end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
    for (int i = 0; i < 20; i++) begin
      eid = 3'(i + 1);
      set_cmd(i[0], 32'(i), 32'd3);
      #1;
      vec_cnt++; if (output_req.req !== 1'b1 || output_req.req_id !== eid) begin err_cnt++; $display("FAIL wrap_id_%0d: got req=%0b id=%0d expected 1/%0d", i, output_req.req, output_req.req_id, eid); end
      tick();
      cmd_valid = 1'b0;
      set_rsp(eid, 64'(i * 3));
      tick();
      input_rsp = '0;
      vec_cnt++; if (res_valid !== 1'b1 || res_id !== eid || res_data !== 64'(i * 3)) begin err_cnt++; $display("FAIL wrap_res_%0d: got v=%0b id=%0d d=%0d expected 1/%0d/%0d", i, res_valid, res_id, res_data, eid, i * 3); end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
    vec_cnt++; if (outstanding !== 4'd0 || proto_err !== 1'b0) begin err_cnt++; $display("FAIL wrap_end: got out=%0d perr=%0b expected 0/0", outstanding, proto_err); end
  endtask

  task automatic test_errors();
    int waited;
    do_reset();
    set_rsp(3'd5, 64'd77);
    tick();
    input_rsp = '0;
    vec_cnt++; if (proto_err !== 1'b1 || res_valid !== 1'b0) begin err_cnt++; $display("FAIL err_stray_rsp: got perr=%0b v=%0b expected 1/0", proto_err, res_valid); end
    do_reset();
    set_cmd(1'b1, 32'd2, 32'd2);
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c < 200; c++) tick();
    vec_cnt++; if (timeout_err !== 1'b0) begin err_cnt++; $display("FAIL err_tmo_early: got %0b expected 0", timeout_err); end
    waited = 0;
    while (timeout_err !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    vec_cnt++; if (timeout_err !== 1'b1) begin err_cnt++; $display("FAIL err_tmo: got %0b expected 1", timeout_err); end
    vec_cnt++; if (waited < 50 || waited > 62) begin err_cnt++; $display("FAIL err_tmo_time: got %0d extra cycles expected 50..62", waited); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_cmd(1'b0, 32'(i), 32'd1);
      tick();
    end
    idle_inputs();
    vec_cnt++; if (outstanding !== 4'd3) begin err_cnt++; $display("FAIL mid_before: got %0d expected 3", outstanding); end
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    vec_cnt++; if (outstanding !== 4'd0 || res_valid !== 1'b0 || proto_err !== 1'b0) begin err_cnt++; $display("FAIL mid_after: got out=%0d v=%0b perr=%0b expected 0/0/0", outstanding, res_valid, proto_err); end
    set_rsp(3'd1, 64'd5);
    tick();
    input_rsp = '0;
    vec_cnt++; if (proto_err !== 1'b1 || res_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_late_rsp: got perr=%0b v=%0b expected 1/0", proto_err, res_valid); end
  endtask

  initial begin
    idle_inputs();
    rst_b = 1'b0;
    test_reset();
    test_single_add();
    test_out_of_order();
    test_backpressure();
    test_capacity_wrap();
    test_errors();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
